// File: rtl/dma_responder.sv
// Two independent DMA engines: the read side streams memory words into a show-ahead
// FIFO, and the write side drains a FIFO of pushed words into memory.
module dma_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic                  wr_go,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ack
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [SIZE_WIDTH-1:0] ONE     = SIZE_WIDTH'(1);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DRAIN} rd_state_t;
  typedef enum logic       {W_IDLE, W_ACTIVE}         wr_state_t;

  // ---------------------------------------------------------------- read side
  rd_state_t             rd_state;
  logic [SIZE_WIDTH-1:0] rd_remain;
  logic [DATA_WIDTH-1:0] rd_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_wp;
  logic [PTR_W-1:0]      rd_rp;
  logic [CNT_W-1:0]      rd_cnt;
  logic                  rd_push;
  logic                  rd_pop;

  // Request only with a guaranteed landing slot; a pending request cannot lose
  // its slot because only its own ack can fill the FIFO.
  assign mem_rd_req = (rd_state == R_FETCH) && (rd_cnt != DEPTH_C);
  assign rd_push    = mem_rd_req && mem_rd_ack;
  assign rd_pop     = rd_en && (rd_cnt != '0);
  assign empty      = (rd_cnt == '0);
  assign rd_data    = empty ? '0 : rd_mem[rd_rp];

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wp] <= mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wp  <= '0;
      rd_rp  <= '0;
      rd_cnt <= '0;
    end else begin
      if (rd_push) rd_wp <= rd_wp + PTR_W'(1);
      if (rd_pop)  rd_rp <= rd_rp + PTR_W'(1);
      case ({rd_push, rd_pop})
        2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
        2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state    <= R_IDLE;
      rd_remain   <= '0;
      mem_rd_addr <= '0;
      rd_done     <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_go) begin
            mem_rd_addr <= rd_addr;
            rd_remain   <= rd_size;
            rd_done     <= 1'b0;
            rd_state    <= (rd_size == '0) ? R_DRAIN : R_FETCH;
          end
        end
        R_FETCH: begin
          if (rd_push) begin
            mem_rd_addr <= mem_rd_addr + STRIDE;
            rd_remain   <= rd_remain - ONE;
            if (rd_remain == ONE) rd_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          // Completion means the consumer has taken every word, not just fetched.
          if (rd_cnt == '0) begin
            rd_done  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t             wr_state;
  logic [SIZE_WIDTH-1:0] wr_len;
  logic [SIZE_WIDTH-1:0] wr_accepted;
  logic [SIZE_WIDTH-1:0] wr_acked;
  logic [DATA_WIDTH-1:0] wr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_wp;
  logic [PTR_W-1:0]      wr_rp;
  logic [CNT_W-1:0]      wr_cnt;
  logic                  wr_push;
  logic                  wr_pop;

  assign full        = (wr_cnt == DEPTH_C);
  assign wr_push     = wr_en && (wr_state == W_ACTIVE) && !full && (wr_accepted < wr_len);
  assign mem_wr_req  = (wr_cnt != '0);
  assign wr_pop      = mem_wr_req && mem_wr_ack;
  assign mem_wr_data = mem_wr_req ? wr_mem[wr_rp] : '0;

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (wr_push) wr_wp <= wr_wp + PTR_W'(1);
      if (wr_pop)  wr_rp <= wr_rp + PTR_W'(1);
      case ({wr_push, wr_pop})
        2'b10:   wr_cnt <= wr_cnt + CNT_W'(1);
        2'b01:   wr_cnt <= wr_cnt - CNT_W'(1);
        default: wr_cnt <= wr_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= W_IDLE;
      wr_len      <= '0;
      wr_accepted <= '0;
      wr_acked    <= '0;
      mem_wr_addr <= '0;
      wr_done     <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_go) begin
            mem_wr_addr <= wr_addr;
            wr_len      <= wr_size;
            wr_accepted <= '0;
            wr_acked    <= '0;
            // A zero-length transfer completes without ever leaving idle.
            wr_done     <= (wr_size == '0);
            wr_state    <= (wr_size == '0) ? W_IDLE : W_ACTIVE;
          end
        end
        W_ACTIVE: begin
          if (wr_push) wr_accepted <= wr_accepted + ONE;
          if (wr_pop) begin
            mem_wr_addr <= mem_wr_addr + STRIDE;
            wr_acked    <= wr_acked + ONE;
            if (wr_acked == wr_len - ONE) begin
              wr_done  <= 1'b1;
              wr_state <= W_IDLE;
            end
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_responder.sv
// Bench for dma_responder: a memory model at the falling edge feeds scoreboard queues
// for read data and expected writes; table-driven read/write transfers plus corner cases.
module tb_dma_responder;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 16;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_go = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [SW-1:0] rd_size = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic          wr_go = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [SW-1:0] wr_size = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          wr_done;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ack = 1'b0;

  dma_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'd17;
  endfunction

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;

  logic [31:0] rd_exp_q[$];
  wr_t         wr_exp_q[$];
  bit          rd_ack_on = 0;
  bit          ack_spur  = 0;
  int          wr_delay  = 0;
  int          rd_acks = 0, wr_acks = 0, rd_pops = 0;
  logic [31:0] rd_next_addr = '0, rd_last_addr = '0;
  int          wwait = 0;
  bit          w_pending = 0;
  logic [31:0] w_prev_a = '0, w_prev_d = '0;
  wr_t         we;

  // Memory model and scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rd_en && !empty) begin
      rd_pops++;
      if (rd_exp_q.size() == 0) chk("rd_pop_unexpected", 1, 0);
      else chk("rd_data", rd_data, rd_exp_q.pop_front());
    end
    if (mem_rd_req && rd_ack_on) begin
      chk("mem_rd_addr", mem_rd_addr, rd_next_addr);
      rd_last_addr = mem_rd_addr;
      rd_next_addr = rd_next_addr + 32'd4;
      rd_exp_q.push_back(rmem(mem_rd_addr));
      mem_rd_data = rmem(mem_rd_addr);
      mem_rd_ack  = 1'b1;
      rd_acks++;
    end else begin
      mem_rd_ack  = ack_spur;
      mem_rd_data = 32'hDEAD_BEEF;
    end
    if (mem_wr_req) begin
      if (w_pending) begin
        chk("wr_addr_stable", mem_wr_addr, w_prev_a);
        chk("wr_data_stable", mem_wr_data, w_prev_d);
      end
      if (wwait >= wr_delay) begin
        if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          we = wr_exp_q.pop_front();
          chk("mem_wr_addr", mem_wr_addr, we.a);
          chk("mem_wr_data", mem_wr_data, we.d);
        end
        mem_wr_ack = 1'b1;
        wwait = 0;
        w_pending = 0;
        wr_acks++;
      end else begin
        mem_wr_ack = 1'b0;
        wwait++;
        w_pending = 1;
        w_prev_a = mem_wr_addr;
        w_prev_d = mem_wr_data;
      end
    end else begin
      mem_wr_ack = ack_spur;
      wwait = 0;
      w_pending = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_done(input int bound);
    for (int i = 0; i < bound && !rd_done; i++) step();
    chk("rd_done_reached", rd_done, 1);
  endtask

  task automatic wait_wr_done(input int bound);
    for (int i = 0; i < bound && !wr_done; i++) step();
    chk("wr_done_reached", wr_done, 1);
  endtask

  task automatic start_rd(input logic [31:0] a, input logic [15:0] s);
    rd_acks = 0; rd_pops = 0; rd_next_addr = a;
    rd_go = 1; rd_addr = a; rd_size = s;
    step();
    rd_go = 0;
  endtask

  typedef struct {logic [31:0] addr; logic [15:0] size; logic [31:0] last;} rd_vec_t;
  typedef struct {logic [31:0] addr; logic [15:0] size; int npush; int delay; int nwr; logic [31:0] dbase;} wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rv[0] = '{32'h0000_1000, 16'd4, 32'h0000_100C};
    rv[1] = '{32'hFFFF_FFFC, 16'd2, 32'h0000_0000};
    rv[2] = '{32'h0000_3000, 16'd1, 32'h0000_3000};
    rv[3] = '{32'h0000_4000, 16'd0, 32'h0000_0000};
    wv[0] = '{32'h0000_6000, 16'd0, 1, 0, 0, 32'h0000_0100};
    wv[1] = '{32'h0000_2000, 16'd3, 3, 2, 3, 32'h0000_000A};
    wv[2] = '{32'h0000_5000, 16'd2, 3, 0, 2, 32'h0000_0200};
    wv[3] = '{32'hFFFF_FFF8, 16'd3, 3, 1, 3, 32'h0000_0300};

    // Reset state
    repeat (3) step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_mem_wr_req", mem_wr_req, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    rst_n = 1;
    step();

    // Acks with no request outstanding must have no effect
    ack_spur = 1;
    repeat (3) step();
    ack_spur = 0;
    step();
    chk("spur_empty", empty, 1);
    chk("spur_full", full, 0);
    chk("spur_wr_req", mem_wr_req, 0);
    chk("spur_rd_done", rd_done, 0);

    // Read table: memory acks every cycle, consumer pops every cycle
    rd_ack_on = 1;
    rd_en = 1;
    foreach (rv[k]) begin
      start_rd(rv[k].addr, rv[k].size);
      chk("rd_done_clear", rd_done, 0);
      wait_rd_done(100);
      chk("rd_ack_count", rd_acks, rv[k].size);
      chk("rd_pop_count", rd_pops, rv[k].size);
      if (rv[k].size != 0) chk("rd_last_addr", rd_last_addr, rv[k].last);
      chk("rd_end_empty", empty, 1);
      chk("rd_queue_drained", rd_exp_q.size(), 0);
    end

    // FIFO fills with no consumer: fetch stops at depth, resumes after one pop
    rd_en = 0;
    start_rd(32'h7000, 16'd20);
    repeat (40) step();
    chk("fill_acks", rd_acks, FD);
    chk("fill_req_low", mem_rd_req, 0);
    chk("fill_not_empty", empty, 0);
    rd_go = 1; rd_addr = 32'h9000; rd_size = 16'd1;
    step();
    rd_go = 0;
    repeat (2) step();
    chk("busy_go_ignored_req", mem_rd_req, 0);
    chk("busy_go_ignored_acks", rd_acks, FD);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("rd_req_reassert", mem_rd_req, 1);
    rd_en = 1;
    wait_rd_done(200);
    chk("fill_total_acks", rd_acks, 20);
    chk("fill_total_pops", rd_pops, 20);
    chk("fill_last_addr", rd_last_addr, 32'h704C);
    chk("fill_queue_drained", rd_exp_q.size(), 0);

    // Reset in the middle of a fetch with three words buffered
    rd_en = 0;
    start_rd(32'h8000, 16'd10);
    for (int i = 0; i < 50 && rd_acks < 3; i++) step();
    rd_ack_on = 0;
    chk("mid_acks", rd_acks, 3);
    chk("mid_buffered", empty, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rd_req", mem_rd_req, 0);
    chk("mid_rst_rd_done", rd_done, 0);
    rd_exp_q.delete();
    step();
    rst_n = 1;
    step();
    rd_ack_on = 1;
    rd_en = 1;
    start_rd(32'hA000, 16'd1);
    wait_rd_done(50);
    chk("post_rst_acks", rd_acks, 1);
    chk("post_rst_pops", rd_pops, 1);
    chk("post_rst_addr", rd_last_addr, 32'hA000);
    rd_en = 0;

    // Write table
    foreach (wv[k]) begin
      wr_acks = 0;
      wr_delay = wv[k].delay;
      wr_go = 1; wr_addr = wv[k].addr; wr_size = wv[k].size;
      step();
      wr_go = 0;
      chk("wr_done_after_go", wr_done, (wv[k].size == 0) ? 1 : 0);
      for (int i = 0; i < wv[k].npush; i++) begin
        if (i < int'(wv[k].size))
          wr_exp_q.push_back('{wv[k].addr + 32'(4 * i), wv[k].dbase + 32'(i)});
        wr_en = 1;
        wr_data = wv[k].dbase + 32'(i);
        step();
      end
      wr_en = 0;
      wait_wr_done(100);
      repeat (5) step();
      chk("wr_count", wr_acks, wv[k].nwr);
      chk("wr_queue_drained", wr_exp_q.size(), 0);
      chk("wr_req_idle", mem_wr_req, 0);
      chk("wr_full_idle", full, 0);
    end

    // Write FIFO full: extra pushes dropped, transfer finishes with later pushes
    wr_acks = 0;
    wr_delay = 100000;
    wr_go = 1; wr_addr = 32'h3000; wr_size = 16'd20;
    step();
    wr_go = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < FD) wr_exp_q.push_back('{32'h3000 + 32'(4 * i), 32'hC000 + 32'(i)});
      wr_en = 1;
      wr_data = 32'hC000 + 32'(i);
      step();
    end
    wr_en = 0;
    chk("wr_full", full, 1);
    chk("wr_full_no_acks", wr_acks, 0);
    wr_delay = 0;
    repeat (20) step();
    chk("wr_drained_not_full", full, 0);
    chk("wr_not_done_yet", wr_done, 0);
    for (int i = 0; i < 4; i++) begin
      wr_exp_q.push_back('{32'h3000 + 32'(4 * (FD + i)), 32'hD000 + 32'(i)});
      wr_en = 1;
      wr_data = 32'hD000 + 32'(i);
      step();
    end
    wr_en = 0;
    wait_wr_done(100);
    chk("wr_full_total", wr_acks, 20);
    chk("wr_full_queue_drained", wr_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dma_responder.md
DMA_RESPONDER -- requirements
Module: dma_responder

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, word width; ADDR_WIDTH, 32, byte address width; SIZE_WIDTH, 16, transfer length width in words; FIFO_DEPTH, 16, entries per direction, power of two >= 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
rd_go  in  1  start a read transfer
rd_addr  in  ADDR_WIDTH  read start byte address
rd_size  in  SIZE_WIDTH  read length in words
rd_en  in  1  pop read FIFO head
rd_data  out  DATA_WIDTH  read FIFO head (show-ahead)
empty  out  1  read FIFO empty
rd_done  out  1  read transfer complete
wr_go  in  1  start a write transfer
wr_addr  in  ADDR_WIDTH  write start byte address
wr_size  in  SIZE_WIDTH  write length in words
wr_en  in  1  push wr_data
wr_data  in  DATA_WIDTH  write word
full  out  1  write FIFO full
wr_done  out  1  write transfer complete
mem_rd_req  out  1  memory read request
mem_rd_addr  out  ADDR_WIDTH  memory read byte address
mem_rd_ack  in  1  read data valid this cycle
mem_rd_data  in  DATA_WIDTH  memory read data
mem_wr_req  out  1  memory write request
mem_wr_addr  out  ADDR_WIDTH  memory write byte address
mem_wr_data  out  DATA_WIDTH  memory write data
mem_wr_ack  in  1  write accepted this cycle

Function
REQ-003 Read and write engines independent; run concurrently, no shared state.
REQ-004 Read FSM states R_IDLE, R_FETCH, R_DRAIN; rd_go in R_IDLE latches rd_addr/rd_size, clears rd_done, enters R_FETCH (or R_DRAIN if rd_size==0); rd_go outside R_IDLE ignored.
REQ-005 R_FETCH: mem_rd_req asserted only if FIFO has >=1 free slot; addr/req held stable until mem_rd_ack; at most one outstanding request.
REQ-006 On mem_rd_ack: mem_rd_data pushed to read FIFO same edge; address += DATA_WIDTH/8 (modulo 2^ADDR_WIDTH wrap); remaining count -=1; count reaching 0 -> R_DRAIN.
REQ-007 R_DRAIN: when read FIFO empty, rd_done set to 1, FSM -> R_IDLE; rd_done holds until next accepted rd_go.
REQ-008 rd_en pops head when empty==0; rd_en with empty==1 ignored; simultaneous push and pop legal in any occupancy.
REQ-009 Write FSM states W_IDLE, W_ACTIVE; wr_go in W_IDLE latches wr_addr/wr_size, clears wr_done, enters W_ACTIVE (size 0: wr_done set next cycle, stay W_IDLE); wr_go in W_ACTIVE ignored.
REQ-010 wr_en pushes wr_data only if W_ACTIVE, full==0, and accepted-word count < wr_size; all other wr_en dropped without effect.
REQ-011 mem_wr_req asserted whenever write FIFO non-empty; mem_wr_data = FIFO head, mem_wr_addr = current address; both stable until mem_wr_ack; ack pops head, address += DATA_WIDTH/8 (wrap).
REQ-012 When wr_size words acked by memory: wr_done set to 1, FSM -> W_IDLE; holds until next accepted wr_go.
REQ-013 empty and full are registered FIFO state, not combinational on inputs; latency from mem_rd_ack to empty==0 is one cycle.
REQ-014 mem_*_ack while corresponding req low ignored.

Reset
REQ-015 rst_n low asynchronously: both FSMs idle, FIFOs flushed, counters/addresses 0; empty=1, full=0, rd_done=0, wr_done=0, mem_rd_req=0, mem_wr_req=0, rd_data/mem_* data and address outputs 0.
REQ-016 Reset mid-transfer abandons the transfer; no done asserted; next go starts fresh.

Verification
REQ-017 rd_go addr=0x1000 size=4, memory acks every cycle, rd_en held 1 -> mem_rd_addr 0x1000,0x1004,0x1008,0x100C; 4 words popped in order; rd_done=1 after last pop.
REQ-018 rd_go size=20, FIFO_DEPTH=16, rd_en=0 -> exactly 16 acks then mem_rd_req=0; popping one word re-asserts mem_rd_req next cycle.
REQ-019 wr_go addr=0x2000 size=3, push 0xA,0xB,0xC, mem_wr_ack delayed 2 cycles each -> writes (0x2000,0xA),(0x2004,0xB),(0x2008,0xC), req/data stable while waiting; wr_done=1 after third ack.
REQ-020 wr_go size=2, push 3 words -> third dropped; only 2 memory writes; wr_done=1.
REQ-021 rd_go addr=0xFFFFFFFC size=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-022 rst_n low during R_FETCH with 3 words buffered -> empty=1, mem_rd_req=0, rd_done=0 immediately; after release new rd_go size=1 completes normally.
